// File: rtl/ring_counter_param.sv
// WIDTH-bit shift counter, run-time selectable between one-hot ring and Johnson modes.
// Supports enable, up/down, synchronous load, illegal-state correction, wrap/err pulses.
module ring_counter_param #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [IDXW-1:0]  pos,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] state_q;
    logic             mode_q;
    logic [WIDTH-1:0] step_nxt;
    logic             cur_legal;
    int unsigned      pc;

    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    // Johnson codes are 1s anchored at the LSB, or their complement (1s anchored at the MSB).
    function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] inv;
        logic [WIDTH-1:0] s_inc;
        logic [WIDTH-1:0] inv_inc;
        inv     = ~s;
        s_inc   = s + WIDTH'(1);
        inv_inc = inv + WIDTH'(1);
        if (!m) begin
            return $onehot(s);
        end
        return ((s & s_inc) == '0) || ((inv & inv_inc) == '0);
    endfunction

    assign state     = state_q;
    assign cur_legal = is_legal(mode_q, state_q);

    always_comb begin
        step_nxt = state_q;
        unique case ({mode_q, dir})
            2'b00: step_nxt = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
            2'b01: step_nxt = {state_q[0], state_q[WIDTH-1:1]};
            2'b10: step_nxt = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
            2'b11: step_nxt = {~state_q[0], state_q[WIDTH-1:1]};
            default: step_nxt = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= seed_of(mode);
            mode_q  <= mode;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else if (mode != mode_q) begin
            state_q <= seed_of(mode);
            mode_q  <= mode;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (is_legal(mode_q, load_val)) begin
                state_q <= load_val;
                err     <= 1'b0;
            end else begin
                state_q <= seed_of(mode_q);
                err     <= 1'b1;
            end
        end else if (!cur_legal) begin
            // Self-correct even while disabled so a corrupted state never lingers.
            state_q <= seed_of(mode_q);
            wrap    <= 1'b0;
            err     <= 1'b1;
        end else if (en) begin
            state_q <= step_nxt;
            err     <= 1'b0;
            wrap    <= (step_nxt == seed_of(mode_q));
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

    always_comb begin
        pos = '0;
        pc  = $countones(state_q);
        if (cur_legal) begin
            if (!mode_q) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (state_q[i]) begin
                        pos = IDXW'(i);
                    end
                end
            end else if (state_q[0] || (state_q == '0)) begin
                pos = IDXW'(pc);
            end else begin
                pos = IDXW'(2 * WIDTH - pc);
            end
        end
    end

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed, table-driven bench for ring_counter_param (WIDTH=4 and WIDTH=8 instances).
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       reset, en, dir, mode, load;
    logic [3:0] load_val;
    logic [3:0] state;
    logic [2:0] pos;
    logic       wrap, err;

    logic       reset8, en8, dir8, mode8, load8;
    logic [7:0] load_val8;
    logic [7:0] state8;
    logic [3:0] pos8;
    logic       wrap8, err8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       en, dir, mode, load;
        logic [3:0] lv;
        logic [3:0] st;
        logic [2:0] p;
        logic       w, e;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .state(state), .pos(pos), .wrap(wrap), .err(err)
    );

    ring_counter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .dir(dir8), .mode(mode8), .load(load8),
        .load_val(load_val8), .state(state8), .pos(pos8), .wrap(wrap8), .err(err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en_, input logic dir_, input logic mode_, input logic load_,
                       input logic [3:0] lv_, input logic [3:0] st_, input logic [2:0] p_,
                       input logic w_, input logic e_);
        vec_t v;
        v.en = en_; v.dir = dir_; v.mode = mode_; v.load = load_; v.lv = lv_;
        v.st = st_; v.p = p_; v.w = w_; v.e = e_;
        vecs.push_back(v);
    endtask

    initial begin
        // en dir mode load load_val | state pos wrap err
        // Ring up, wrap back to seed, then hold.
        add(1, 0, 0, 0, 4'h0, 4'b0010, 3'd1, 0, 0);
        add(1, 0, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
        add(1, 0, 0, 0, 4'h0, 4'b1000, 3'd3, 0, 0);
        add(1, 0, 0, 0, 4'h0, 4'b0001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 4'h0, 4'b0001, 3'd0, 0, 0);
        // Ring down and reversal retrace.
        add(1, 1, 0, 0, 4'h0, 4'b1000, 3'd3, 0, 0);
        add(1, 1, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
        add(1, 0, 0, 0, 4'h0, 4'b1000, 3'd3, 0, 0);
        add(1, 1, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
        // Mode switch to Johnson and back.
        add(0, 0, 1, 0, 4'h0, 4'b0000, 3'd0, 0, 0);
        add(0, 0, 0, 0, 4'h0, 4'b0001, 3'd0, 0, 0);
        // Ring loads: illegal then legal.
        add(0, 0, 0, 1, 4'b0110, 4'b0001, 3'd0, 0, 1);
        add(0, 0, 0, 1, 4'b0100, 4'b0100, 3'd2, 0, 0);
        // Johnson full cycle up.
        add(0, 0, 1, 0, 4'h0, 4'b0000, 3'd0, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b0001, 3'd1, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b0011, 3'd2, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b0111, 3'd3, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b1110, 3'd5, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b1100, 3'd6, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b1000, 3'd7, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'b0000, 3'd0, 1, 0);
        // Johnson down.
        add(1, 1, 1, 0, 4'h0, 4'b1000, 3'd7, 0, 0);
        add(1, 1, 1, 0, 4'h0, 4'b1100, 3'd6, 0, 0);
        add(1, 1, 1, 0, 4'h0, 4'b1110, 3'd5, 0, 0);
        // Johnson loads: legal then illegal (load beats step).
        add(1, 0, 1, 1, 4'b1100, 4'b1100, 3'd6, 0, 0);
        add(1, 0, 1, 1, 4'b0101, 4'b0000, 3'd0, 0, 1);
        add(1, 0, 1, 0, 4'h0, 4'b0001, 3'd1, 0, 0);
        // Down-step wrapping onto the Johnson seed.
        add(1, 1, 1, 0, 4'h0, 4'b0000, 3'd0, 1, 0);

        reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        reset8 = 1'b0; en8 = 1'b0; dir8 = 1'b0; mode8 = 1'b0; load8 = 1'b0; load_val8 = '0;
        #12;
        check("reset state", 32'(state), 32'b0001);
        check("reset pos", 32'(pos), 32'd0);
        check("reset wrap", 32'(wrap), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset8 state", 32'(state8), 32'h01);
        reset = 1'b1;
        reset8 = 1'b1;
        tick();
        check("release hold", 32'(state), 32'b0001);

        foreach (vecs[i]) begin
            en = vecs[i].en; dir = vecs[i].dir; mode = vecs[i].mode;
            load = vecs[i].load; load_val = vecs[i].lv;
            tick();
            check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d pos", i), 32'(pos), 32'(vecs[i].p));
            check($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].w));
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e));
        end

        // Illegal Johnson state injected with en=0.
        en = 1'b0; dir = 1'b0; mode = 1'b1; load = 1'b0;
        tick();
        force dut.state_q = 4'b1010;
        #1;
        check("illegal pos", 32'(pos), 32'd0);
        tick();
        check("illegal err", 32'(err), 32'd1);
        check("illegal wrap", 32'(wrap), 32'd0);
        release dut.state_q;
        tick();
        check("illegal corrected", 32'(state), 32'b0000);
        tick();
        check("err cleared", 32'(err), 32'd0);

        // Async reset mid-count in Johnson mode.
        en = 1'b1;
        tick(); tick(); tick();
        check("pre-reset state", 32'(state), 32'b0111);
        check("pre-reset pos", 32'(pos), 32'd3);
        #3;
        reset = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'b0000);
        check("async reset wrap", 32'(wrap), 32'd0);
        en = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("post-reset hold", 32'(state), 32'b0000);
        check("post-reset wrap", 32'(wrap), 32'd0);
        tick();
        check("en0 hold", 32'(state), 32'b0000);

        // WIDTH=8 ring: eight steps back to seed.
        en8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("w8 step%0d state", k), 32'(state8), 32'h1 << (k % 8));
            check($sformatf("w8 step%0d pos", k), 32'(pos8), 32'(k % 8));
            check($sformatf("w8 step%0d wrap", k), 32'(wrap8), 32'(k == 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_counter_param.md
Name: ring_counter_param

Overview:
Parametrised successor to the 4-bit ring counter: a WIDTH-bit shift counter selectable at run time between one-hot ring mode and Johnson (twisted-ring) mode. It adds enable, up/down direction, synchronous load, detection and self-correction of illegal states, a wrap pulse and a binary position decode. It serves as a sequencer/phase generator for lab-board timing blocks.

Parameters:
WIDTH, 4, number of state bits; legal range ≥ 2.
IDXW, $clog2(2*WIDTH), width of the position output; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  step enable; one step per clock while high.
dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
mode  input  1  0 = ring (one-hot), 1 = Johnson.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value applied on load.
state  output  WIDTH  registered counter state.
pos  output  IDXW  combinational decode of state into a step index.
wrap  output  1  registered one-cycle pulse: a step returned state to seed.
err  output  1  registered one-cycle pulse: illegal state or illegal load corrected.

Behaviour:
- Seed: ring = 0…01 (bit 0 set); Johnson = 0…0.
- Reset (reset=0, async): state = seed(mode input at reset), mode_q = mode, wrap = 0, err = 0.
- Legality: ring = exactly one bit set. Johnson = contiguous 1s anchored at LSB (includes all-0/all-1) or contiguous 1s anchored at MSB; 2*WIDTH legal codes.
- Per-edge priority, highest first:
  1. mode != mode_q: state <= seed(mode), mode_q <= mode, wrap <= 0, err <= 0.
  2. load: if load_val is legal for mode_q, state <= load_val, err <= 0; else state <= seed, err <= 1. wrap <= 0.
  3. Current state illegal: state <= seed, err <= 1, wrap <= 0. This applies regardless of en.
  4. en=1: step. err <= 0. wrap <= 1 iff the next state == seed.
     - ring up = {s[W-2:0], s[W-1]}; ring down = {s[0], s[W-1:1]}.
     - Johnson up = {s[W-2:0], ~s[W-1]}; Johnson down = {~s[0], s[W-1:1]}.
  5. Otherwise: hold state; wrap <= 0, err <= 0.
- Period: ring = WIDTH steps; Johnson = 2*WIDTH steps, in both directions.
- pos (combinational, 0 latency):
  - Ring: index of the set bit.
  - Johnson: if s[0]=1 or s=0, pos = popcount(s); else pos = 2*WIDTH − popcount(s).
  - Illegal state: pos = 0.
- wrap and err are never both 1. Each is high exactly one cycle per event.
- Reset asserted mid-sequence takes effect immediately; release is synchronous to the next clk edge (no step on the release edge unless en=1).
- dir change takes effect on the next step with no extra latency. Reversing direction retraces the sequence exactly.

Test Plan:
1. WIDTH=4, mode=0, en=1, dir=0, from reset -> state 0001,0010,0100,1000,0001; pos 0,1,2,3,0; wrap high only the cycle state returns to 0001.
2. mode=1, en=1, dir=0 from reset -> 0000,0001,0011,0111,1111,1110,1100,1000,0000; pos 0..7,0; wrap once per 8 cycles. Then dir=1 -> sequence reverses (1000 after 0000).
3. Ring mode at 0100, mode switched to 1 -> next edge state=0000, no wrap/err. Switch back -> 0001.
4. load=1, load_val=0110 in ring mode -> state=0001, err=1 for one cycle. load_val=0100 -> state=0100, err=0. In Johnson mode, load_val=1100 is accepted; load_val=0101 -> seed 0000 with err pulse.
5. Bench forces state=1010 in Johnson mode with en=0 -> next edge state=0000, err=1; pos=0 while the illegal value is present.
6. reset driven low mid-count at state 0111 between edges -> state=0000 immediately (mode=1); en=0 holds state with wrap=0; WIDTH=8 ring wraps after 8 steps with pos 0..7.
